// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Valid/ready stream carrying words out of the async FIFO read side.
//   m_valid  : word on m_data is available (driven by the FIFO reader)
//   m_ready  : sink accepts the word this cycle (driven by the sink)
//   m_data   : stream data word
// Modports: master = FIFO reader side, slave = stream sink side.
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
    parameter int DATASIZE = 8
);
    logic                m_valid;
    logic                m_ready;
    logic [DATASIZE-1:0] m_data;

    modport master (output m_valid, output m_data, input  m_ready);
    modport slave  (input  m_valid, input  m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side consumer of the async FIFO (rclk domain). Issues rinc towards the
// read-pointer logic / RAM read port, captures the 1-cycle-latency RAM data into
// a 2-entry skid buffer and presents it as a first-word-fall-through stream that
// sustains one word per clock. Also reports a registered fill level derived from
// the synchronized gray pointers.
// Ports:
//   rclk      : read-domain clock
//   rrst_n    : asynchronous active-low reset
//   rempty    : registered empty flag (already reflects rinc)
//   rptr      : gray read pointer, ADDRSIZE+1 bits
//   rq2_wptr  : gray write pointer synchronized into rclk
//   rdata     : RAM read data, valid the cycle after rinc
//   rinc      : read-increment / RAM read enable (only combinational output)
//   rd_level  : words left in the FIFO RAM, excluding skid-buffer contents
//   m         : stream master (m_valid, m_ready, m_data)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic [ADDRSIZE:0]   rd_level,
    fifo_rd_stream_if.master    m
);
    logic [1:0]          r_buf_cnt;   // words held in the skid buffer (0..2)
    logic                r_inflight;  // rinc of the previous cycle: rdata valid now
    logic [DATASIZE-1:0] r_mem [2];
    logic                r_head;
    logic                r_tail;
    logic [ADDRSIZE:0]   r_level;

    logic                w_pop;
    logic [1:0]          w_occ;
    logic [ADDRSIZE:0]   w_wbin;
    logic [ADDRSIZE:0]   w_rbin;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_pop = (r_buf_cnt != 2'd0) & m.m_ready;

    // Occupancy counts words already buffered plus the one whose RAM read is in
    // flight, so two reservations are never exceeded.
    assign w_occ = r_buf_cnt + {1'b0, r_inflight};

    // A full buffer may still request a read when the head leaves this cycle:
    // the new word lands one cycle later, into the slot being freed now.
    // Gated by rrst_n so no read is requested while reset is held.
    assign rinc = rrst_n & ~rempty &
                  ((w_occ < 2'd2) | ((w_occ == 2'd2) & w_pop));

    assign w_wbin = gray2bin(rq2_wptr);
    assign w_rbin = gray2bin(rptr);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    // NOTE: the two storage words are reset as well; they are plain flops, and
    // resetting them keeps m_data at zero after reset instead of stale data.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_buf_cnt  <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else begin
            r_inflight <= rinc;
            if (r_inflight) begin
                r_mem[r_tail] <= rdata;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_buf_cnt <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Modular subtraction handles the pointer MSB wrap; the result is one cycle
    // behind the pointers and pessimistic because rq2_wptr lags the writer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_level <= '0;
        end else begin
            r_level <= w_wbin - w_rbin;
        end
    end

    assign m.m_valid = (r_buf_cnt != 2'd0);
    assign m.m_data  = r_mem[r_head];
    assign rd_level  = r_level;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Drives fifo_rd_stream from a behavioural model of the FIFO read side (RAM,
// binary pointers, registered empty flag) and checks the stream against a
// scoreboard of written words, plus rinc / m_valid / rd_level against the
// occupancy rules computed from counts of reads issued and words consumed.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int PMASK = (2 * DEPTH) - 1;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rempty;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rq2_wptr;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic [PW-1:0] rd_level;

    fifo_rd_stream_if #(.DATASIZE(DW)) s_if ();

    fifo_rd_stream #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rempty   (rempty),
        .rptr     (rptr),
        .rq2_wptr (rq2_wptr),
        .rdata    (rdata),
        .rinc     (rinc),
        .rd_level (rd_level),
        .m        (s_if.master)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // FIFO read-side model
    logic [DW-1:0] ram [DEPTH];
    int unsigned   rbin = 0;
    int unsigned   wbin = 0;
    logic [DW-1:0] pend_q [$];   // words waiting to be written
    logic [DW-1:0] exp_q  [$];   // words written, not yet consumed
    int            wr_pct   = 100;
    int            rdy_pct  = 100;
    bit            rdy_rand = 1'b0;
    int            outstanding = 0;  // reads issued minus words consumed
    bit            prev_rinc   = 1'b0;
    int unsigned   lvl_exp     = 0;

    // samples of the last tick
    bit            s_rinc, s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic [PW-1:0] s_level;

    // statistics
    int n_rinc, n_pop, rinc_run, pop_run, max_rinc_run, max_pop_run;

    function automatic logic [PW-1:0] gray(input int unsigned b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int unsigned fill();
        return (wbin - rbin) & PMASK;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ptrs();
        rempty   = (rbin == wbin);
        rptr     = gray(rbin);
        rq2_wptr = gray(wbin);
    endtask

    task automatic clear_stats();
        n_rinc = 0; n_pop = 0; rinc_run = 0; pop_run = 0;
        max_rinc_run = 0; max_pop_run = 0;
    endtask

    task automatic model_reset();
        rbin = 0; wbin = 0;
        pend_q.delete();
        exp_q.delete();
        outstanding = 0;
        prev_rinc   = 1'b0;
        lvl_exp     = 0;
        rdata       = '0;
        drive_ptrs();
    endtask

    // One rclk cycle: sample and check at the falling edge, then update the
    // FIFO model just after the rising edge.
    task automatic tick();
        bit            exp_valid, exp_rinc, pop;
        logic [DW-1:0] w;
        @(negedge rclk);
        s_rinc  = rinc;
        s_valid = s_if.m_valid;
        s_ready = s_if.m_ready;
        s_data  = s_if.m_data;
        s_level = rd_level;

        // words read but not consumed, minus the one still on its way from RAM
        exp_valid = (outstanding - int'(prev_rinc)) > 0;
        pop       = exp_valid && s_ready;
        exp_rinc  = !rempty && (outstanding < 2 || (outstanding == 2 && pop));
        check("m_valid", 32'(s_valid), 32'(exp_valid));
        check("rinc", 32'(s_rinc), 32'(exp_rinc));
        check("rd_level", 32'(s_level), lvl_exp);
        if (s_rinc) check("underflow", 32'(rempty), 32'd0);
        if (s_valid && s_ready) begin
            if (exp_q.size() == 0) check("spurious_pop", 32'(s_valid), 32'd0);
            else                   check("m_data", 32'(s_data), 32'(exp_q.pop_front()));
        end

        if (s_rinc) begin
            n_rinc++; rinc_run++;
            if (rinc_run > max_rinc_run) max_rinc_run = rinc_run;
        end else rinc_run = 0;
        if (s_valid && s_ready) begin
            n_pop++; pop_run++;
            if (pop_run > max_pop_run) max_pop_run = pop_run;
        end else pop_run = 0;

        @(posedge rclk);
        #1;
        outstanding += int'(s_rinc) - int'(s_valid && s_ready);
        prev_rinc = s_rinc;
        lvl_exp   = fill();
        if (s_rinc) begin
            rdata = ram[rbin % DEPTH];
            rbin  = (rbin + 1) & PMASK;
        end else begin
            rdata = DW'($urandom);
        end
        if (pend_q.size() > 0 && fill() < DEPTH && $urandom_range(99) < wr_pct) begin
            w = pend_q.pop_front();
            ram[wbin % DEPTH] = w;
            exp_q.push_back(w);
            wbin = (wbin + 1) & PMASK;
        end
        drive_ptrs();
        if (rdy_rand) s_if.m_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0 || outstanding > 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size() + pend_q.size(), 32'd0);
    endtask

    // Place the pointers directly with fill words of random data in the RAM.
    task automatic preload(input int unsigned r, input int unsigned w);
        logic [DW-1:0] d;
        rbin = r; wbin = w;
        for (int i = 0; i < int'(fill()); i++) begin
            d = DW'($urandom);
            ram[(r + i) % DEPTH] = d;
            exp_q.push_back(d);
        end
        drive_ptrs();
    endtask

    initial begin
        rrst_n = 1'b0;
        s_if.m_ready = 1'b0;
        model_reset();
        clear_stats();
        #2;
        check("reset_m_valid", 32'(s_if.m_valid), 32'd0);
        check("reset_m_data", 32'(s_if.m_data), 32'd0);
        check("reset_rd_level", 32'(rd_level), 32'd0);
        check("reset_rinc", 32'(rinc), 32'd0);
        @(posedge rclk); #1;
        rrst_n = 1'b1;
        repeat (2) tick();

        // single word: rinc in cycle k only, word visible in k+2
        s_if.m_ready = 1'b1;
        pend_q.push_back(8'hA5);
        tick();                       // write lands, rempty falls
        tick();
        check("single_rinc_k", 32'(s_rinc), 32'd1);
        check("single_valid_k", 32'(s_valid), 32'd0);
        tick();
        check("single_rinc_k1", 32'(s_rinc), 32'd0);
        check("single_valid_k1", 32'(s_valid), 32'd0);
        tick();
        check("single_valid_k2", 32'(s_valid), 32'd1);
        check("single_data_k2", 32'(s_data), 32'hA5);
        drain(20);

        // streaming 16 words with the sink always ready
        clear_stats();
        for (int i = 0; i < 16; i++) pend_q.push_back(DW'(i));
        drain(100);
        check("stream_rinc_run", max_rinc_run, 32'd16);
        check("stream_pop_run", max_pop_run, 32'd16);
        check("stream_pops", n_pop, 32'd16);

        // back-pressure: 10 words queued, sink stalled
        clear_stats();
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) pend_q.push_back(DW'(8'h30 + i));
        repeat (20) tick();
        check("bp_rinc_pulses", n_rinc, 32'd2);
        check("bp_valid_held", 32'(s_valid), 32'd1);
        check("bp_data_held", 32'(s_data), 32'h30);
        clear_stats();
        s_if.m_ready = 1'b1;
        drain(50);
        check("bp_pops", n_pop, 32'd10);
        check("bp_pop_run", max_pop_run, 32'd10);

        // reset mid-burst with both buffer entries full
        clear_stats();
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) pend_q.push_back(DW'(8'h60 + i));
        repeat (8) tick();
        check("pre_reset_rinc", n_rinc, 32'd2);
        check("pre_reset_valid", 32'(s_valid), 32'd1);
        rrst_n = 1'b0;
        #1;
        check("midrst_m_valid", 32'(s_if.m_valid), 32'd0);
        check("midrst_rinc", 32'(rinc), 32'd0);
        check("midrst_rd_level", 32'(rd_level), 32'd0);
        model_reset();
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
        s_if.m_ready = 1'b1;
        repeat (4) tick();
        pend_q.push_back(8'h11);
        pend_q.push_back(8'h22);
        drain(30);

        // random sink readiness and write rate over 1000 words
        rdy_rand = 1'b1;
        rdy_pct  = 50;
        wr_pct   = 60;
        for (int i = 0; i < 1000; i++) pend_q.push_back(DW'($urandom));
        drain(20000);
        rdy_rand = 1'b0;
        wr_pct   = 100;
        s_if.m_ready = 1'b1;
        repeat (3) tick();

        // level across the pointer wrap: rbin=0x1E, wbin=0x03 -> 5
        s_if.m_ready = 1'b0;
        preload(32'h1E, 32'h03);
        tick();
        tick();
        check("level_wrap", 32'(s_level), 32'd5);
        s_if.m_ready = 1'b1;
        drain(50);

        // level of a completely full FIFO
        s_if.m_ready = 1'b0;
        preload(rbin, (rbin + DEPTH) & PMASK);
        tick();
        tick();
        check("level_full", 32'(s_level), 32'd16);
        s_if.m_ready = 1'b1;
        drain(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
